// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: four-master round-robin arbiter for the RIB slave path.
// Define RIB_ARB_TIMEOUT_EN to force-release a grant stuck for TIMEOUT_CYCLES.
module rib_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic [3:0] lock_i,
    input  logic       done_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_id_o,
    output logic       busy_o,
    output logic       hold_flag_o,
    output logic       timeout_o,
    output logic [1:0] err_id_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last_id;
    logic [1:0] r_gnt_id;
    logic [3:0] r_gnt;
    logic [1:0] w_win_id;
    logic       w_win_vld;
    logic       w_load;
    logic       w_drop;
    logic       w_rel;
    logic       w_own_req;
    logic       w_own_lock;
    logic       w_to;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_W) - 1) begin : g_cfg_chk
        $error("rib_rr_arbiter: TIMEOUT_CYCLES does not fit TO_W");
    end

    assign w_own_req  = req_i[r_gnt_id];
    assign w_own_lock = lock_i[r_gnt_id];

    // An aborted or timed-out grant is released exactly like an unlocked done.
    assign w_rel = ~w_own_req | w_to | (done_i & ~w_own_lock);

    // Scan last_id+4 down to last_id+1 so the nearest requester is written last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = r_last_id;
        for (int k = 4; k >= 1; k--) begin
            if (req_i[r_last_id + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win_id  = r_last_id + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_last_id <= 2'd3;
            r_gnt_id  <= 2'd0;
            r_gnt     <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gnt_id  <= w_win_id;
                r_last_id <= w_win_id;
                r_gnt     <= 4'b0001 << w_win_id;
            end else if (w_drop) begin
                r_gnt <= 4'b0000;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_load      = 1'b1;
                end
            end
            S_GRANT: begin
                if (w_rel) begin
                    if (w_win_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_drop      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = r_gnt;
        gnt_id_o    = r_gnt_id;
        busy_o      = (r_state == S_GRANT);
        hold_flag_o = (r_state == S_GRANT) & ~r_gnt[0];
    end

`ifdef RIB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic [1:0]      r_err_id;

    assign w_to = (r_state == S_GRANT) & ~done_i
                & (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_err_id  <= 2'd0;
        end else begin
            if (r_state != S_GRANT || w_load || done_i) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_timeout <= w_to;
            if (w_to) begin
                r_err_id <= r_gnt_id;
            end
        end
    end

    assign timeout_o = r_timeout;
    assign err_id_o  = r_err_id;
`else
    assign w_to      = 1'b0;
    assign timeout_o = 1'b0;
    assign err_id_o  = 2'd0;
`endif

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: directed vectors for rib_rr_arbiter.
// Expected grant owners are queued by the stimulus and popped by a monitor.
module tb_rib_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       hold;
    logic       tmo;
    logic [1:0] err_id;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_id;

    always #5 clk = ~clk;

    rib_rr_arbiter #(
        .TIMEOUT_CYCLES(4),
        .TO_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .lock_i     (lock),
        .done_i     (done),
        .gnt_o      (gnt),
        .gnt_id_o   (gnt_id),
        .busy_o     (busy),
        .hold_flag_o(hold),
        .timeout_o  (tmo),
        .err_id_o   (err_id)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input int n);
        repeat (n) exp_q.push_back(id);
    endtask

    // Every cycle the bus is owned must match the next queued owner.
    always @(negedge clk) begin
        if (busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got gnt %b expected idle", gnt);
            end else begin
                mon_id = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(4'b0001 << mon_id));
                check("gnt_id", 32'(gnt_id), 32'(mon_id));
                check("hold_flag", 32'(hold), 32'(mon_id != 2'd0));
            end
        end
    end

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        lock = 4'b0000;
        done = 1'b0;
        #12;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hold", 32'(hold), 32'h0);
        check("rst_timeout", 32'(tmo), 32'h0);
        check("rst_err_id", 32'(err_id), 32'h0);
        rst = 1'b1;
        cyc(1);

        // all request, single-cycle slave: 0,1,2,3,0
        push(2'd0, 1);
        push(2'd1, 1);
        push(2'd2, 1);
        push(2'd3, 1);
        push(2'd0, 1);
        req  = 4'b1111;
        done = 1'b1;
        cyc(5);
        req = 4'b0000;
        cyc(1);
        check("rr_idle_busy", 32'(busy), 32'h0);
        check("rr_idle_gnt", 32'(gnt), 32'h0);

        // master 2 locked for 3 done cycles, then 0, then 2 again
        push(2'd2, 3);
        push(2'd0, 1);
        push(2'd2, 1);
        req  = 4'b0101;
        lock = 4'b0100;
        cyc(3);
        lock = 4'b0000;
        cyc(2);
        req = 4'b0000;
        cyc(1);
        check("lock_idle_busy", 32'(busy), 32'h0);

        // owner 3 drops its request without done
        push(2'd3, 3);
        done = 1'b0;
        req  = 4'b1000;
        cyc(3);
        req = 4'b0000;
        cyc(1);
        check("abort_gnt", 32'(gnt), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_hold", 32'(hold), 32'h0);

`ifdef RIB_ARB_TIMEOUT_EN
        push(2'd1, 7);
        req = 4'b0010;
        cyc(6);
        check("to_pulse", 32'(tmo), 32'h1);
        check("to_err_id", 32'(err_id), 32'h1);
        cyc(1);
        check("to_pulse_end", 32'(tmo), 32'h0);
        check("to_err_sticky", 32'(err_id), 32'h1);
        req = 4'b0000;
        cyc(1);
        check("to_idle_busy", 32'(busy), 32'h0);
`else
        push(2'd1, 1000);
        req = 4'b0010;
        cyc(1000);
        check("hold_1000_busy", 32'(busy), 32'h1);
        check("hold_1000_gnt", 32'(gnt), 32'h2);
        check("no_to_pulse", 32'(tmo), 32'h0);
        check("no_to_err", 32'(err_id), 32'h0);
        req = 4'b0000;
        cyc(1);
        check("hold_idle_busy", 32'(busy), 32'h0);
`endif

        // async reset in the middle of a grant to master 3
        req = 4'b1000;
        cyc(1);
        check("pre_rst_gnt", 32'(gnt), 32'h8);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_hold", 32'(hold), 32'h0);
        #2;
        push(2'd0, 1);
        push(2'd3, 1);
        req = 4'b1001;
        rst = 1'b1;
        cyc(1);
        done = 1'b1;
        cyc(1);
        req = 4'b0000;
        cyc(1);
        check("final_idle_busy", 32'(busy), 32'h0);

        cyc(2);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
